universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 Parameter CNT_W, default 4, width of AMT; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 LOAD  input  1  parallel-load request, sampled in IDLE only.
REQ-006 START  input  1  shift-operation request, sampled in IDLE only.
REQ-007 MODE  input  3  operation select, latched at START.
REQ-008 AMT  input  CNT_W  shift count, latched at START.
REQ-009 SIN  input  1  serial data in, sampled live on every shift edge.
REQ-010 D  input  WIDTH  parallel load data.
REQ-011 O  output  WIDTH  register contents (registered).
REQ-012 SOUT  output  1  bit shifted out on the most recent shift (registered).
REQ-013 BUSY  output  1  high while the FSM is in RUN (registered).
REQ-014 DONE  output  1  one-cycle completion pulse (registered).

Function
REQ-015 FSM SHALL have exactly two states: IDLE and RUN.
REQ-016 IDLE, LOAD=1: O<=D next edge; START ignored that cycle (LOAD has priority); SOUT unchanged.
REQ-017 IDLE, LOAD=0, START=1: latch MODE, set count N=min(AMT,WIDTH); N>0 -> RUN; N=0 -> stay IDLE, DONE=1 next cycle, O unchanged.
REQ-018 RUN: each edge performs one 1-bit shift per latched mode and decrements count; the edge performing shift N returns to IDLE and sets DONE=1 for one cycle.
REQ-019 Latency: N shifts occupy N RUN cycles; BUSY high exactly N cycles; DONE high the cycle after the last shift edge.
REQ-020 LOAD, START, MODE, AMT changes SHALL be ignored while in RUN; SIN SHALL be sampled every RUN edge.
REQ-021 MODE 000 SHL: O<={O[W-2:0],0}; SOUT<=O[W-1].
REQ-022 MODE 001 SHR: O<={0,O[W-1:1]}; SOUT<=O[0].
REQ-023 MODE 010 SAR: O<={O[W-1],O[W-1:1]}; SOUT<=O[0].
REQ-024 MODE 011 ROL: O<={O[W-2:0],O[W-1]}; SOUT<=O[W-1].
REQ-025 MODE 100 ROR: O<={O[0],O[W-1:1]}; SOUT<=O[0].
REQ-026 MODE 101 serial-left: O<={O[W-2:0],SIN}; SOUT<=O[W-1].
REQ-027 MODE 110 serial-right: O<={SIN,O[W-1:1]}; SOUT<=O[0].
REQ-028 MODE 111 reserved: FSM runs N cycles with BUSY/DONE timing unchanged, O and SOUT hold.
REQ-029 AMT>WIDTH SHALL be clamped to WIDTH (full rotate returns original value; full logical shift yields 0).
REQ-030 DONE SHALL never be high in the same cycle as BUSY; back-to-back START in the DONE cycle SHALL be accepted.

Reset
REQ-031 RST=1 SHALL immediately force O=0, SOUT=0, BUSY=0, DONE=0, state IDLE, count 0, independent of CLK.
REQ-032 RST asserted during RUN SHALL abort the operation with no DONE pulse; operation SHALL NOT resume after release.

Verification (WIDTH=8, CNT_W=4)
REQ-033 Assert RST mid-cycle -> O=0x00, SOUT=0, BUSY=0, DONE=0 before next CLK edge.
REQ-034 LOAD D=0xB4; START MODE=000 AMT=3 -> BUSY 3 cycles, O=0xA0, SOUT=1, DONE single pulse next cycle.
REQ-035 LOAD D=0x96; START MODE=010 AMT=2 -> O=0xE5, SOUT=1; MODE=100 AMT=9 on 0x81 -> 8 cycles BUSY, O=0x81.
REQ-036 START AMT=0 -> BUSY stays 0, DONE=1 one cycle later, O unchanged; LOAD+START same cycle -> load only, no DONE.
REQ-037 O=0x00, START MODE=101 AMT=4, SIN=1 held -> O=0x0F; new START in DONE cycle accepted.
REQ-038 RST pulse during cycle 2 of a 5-shift op -> O=0x00, no DONE, FSM IDLE after release.

Source files
------------

// File: rtl/universal_shift_reg_if.sv
// Bus bundle for universal_shift_reg: control/data requests in, register state out.
interface universal_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             i_load;
  logic             i_start;
  logic [2:0]       i_mode;
  logic [CNT_W-1:0] i_amt;
  logic             i_sin;
  logic [WIDTH-1:0] i_d;
  logic [WIDTH-1:0] o_o;
  logic             o_sout;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_load, i_start, i_mode, i_amt, i_sin, i_d,
    input  o_o, o_sout, o_busy, o_done
  );

  modport slave (
    input  i_load, i_start, i_mode, i_amt, i_sin, i_d,
    output o_o, o_sout, o_busy, o_done
  );
endinterface

// File: rtl/universal_shift_reg.sv
// Multi-mode shift register: parallel load, then N single-bit shifts under a two-state FSM.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  universal_shift_reg_if.slave bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_mode;
  logic [WIDTH-1:0] r_o;
  logic             r_sout;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_amt_clamp;
  logic [2:0]       w_mode_nxt;
  logic [WIDTH-1:0] w_o_nxt;
  logic             w_sout_nxt;
  logic             w_done_nxt;
  logic [WIDTH:0]   w_shift;

  // One shift step; result is {sout, o}. Reserved mode holds both.
  function automatic logic [WIDTH:0] shift_step(
    input logic [2:0]       mode,
    input logic [WIDTH-1:0] o,
    input logic             sout,
    input logic             sin
  );
    logic [WIDTH:0] res;
    case (mode)
      3'b000:  res = {o[WIDTH-1], o[WIDTH-2:0], 1'b0};
      3'b001:  res = {o[0], 1'b0, o[WIDTH-1:1]};
      3'b010:  res = {o[0], o[WIDTH-1], o[WIDTH-1:1]};
      3'b011:  res = {o[WIDTH-1], o[WIDTH-2:0], o[WIDTH-1]};
      3'b100:  res = {o[0], o[0], o[WIDTH-1:1]};
      3'b101:  res = {o[WIDTH-1], o[WIDTH-2:0], sin};
      3'b110:  res = {o[0], sin, o[WIDTH-1:1]};
      default: res = {sout, o};
    endcase
    return res;
  endfunction

  // Next-state, counter and datapath decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_o_nxt     = r_o;
    w_sout_nxt  = r_sout;
    w_done_nxt  = 1'b0;
    w_shift     = shift_step(r_mode, r_o, r_sout, bus.i_sin);
    if (bus.i_amt > CNT_W'(WIDTH)) begin
      w_amt_clamp = CNT_W'(WIDTH);
    end else begin
      w_amt_clamp = bus.i_amt;
    end
    case (r_state)
      ST_IDLE: begin
        if (bus.i_load) begin
          w_o_nxt = bus.i_d;
        end else if (bus.i_start) begin
          w_mode_nxt = bus.i_mode;
          if (w_amt_clamp != {CNT_W{1'b0}}) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = w_amt_clamp;
          end else begin
            w_done_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        {w_sout_nxt, w_o_nxt} = w_shift;
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers; reset clears everything without waiting for a clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_mode  <= 3'b000;
      r_o     <= {WIDTH{1'b0}};
      r_sout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_o     <= w_o_nxt;
      r_sout  <= w_sout_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= w_done_nxt;
    end
  end

  assign bus.o_o    = r_o;
  assign bus.o_sout = r_sout;
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8): vector table, corner sequences, random ops vs. model.
module tb_universal_shift_reg;
  localparam int W = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  universal_shift_reg_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  universal_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    bit         ld;
    logic [7:0] d;
    logic [2:0] mode;
    logic [3:0] amt;
    bit         sin;
    logic [7:0] exp_o;
    bit         exp_sout;
    int         exp_busy;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Closed-form result of a whole operation: returns {sout, o}.
  function automatic logic [8:0] ref_op(input logic [2:0] mode, input logic [7:0] o,
                                        input logic sout, input logic [3:0] amt,
                                        input logic [15:0] sins);
    int n;
    logic [63:0] v;
    logic [63:0] r;
    logic [63:0] sv;
    logic s;
    n = (amt > 4'd8) ? W : int'(amt);
    v = {56'd0, o};
    if (n == 0 || mode == 3'd7) return {sout, o};
    case (mode)
      3'd0: begin r = v << n; s = v[W-n]; end
      3'd1: begin r = v >> n; s = v[n-1]; end
      3'd2: begin sv = {{56{o[7]}}, o}; r = 64'($signed(sv) >>> n); s = v[n-1]; end
      3'd3: begin r = (v << n) | (v >> (W-n)); s = v[W-n]; end
      3'd4: begin r = (v >> n) | (v << (W-n)); s = v[n-1]; end
      3'd5: begin
        r = v;
        for (int k = 0; k < n; k++) r = ((r << 1) | 64'(sins[k])) & 64'hFF;
        s = v[W-n];
      end
      default: begin
        r = v;
        for (int k = 0; k < n; k++) r = (r >> 1) | (64'(sins[k]) << (W-1));
        s = v[n-1];
      end
    endcase
    return {s, r[7:0]};
  endfunction

  // Optional load, then one START; returns the number of BUSY cycles seen and the SIN bits used.
  task automatic do_op(input bit ld, input logic [7:0] d, input logic [2:0] mode,
                       input logic [3:0] amt, input bit sin_rand, input bit sin_val,
                       output int nbusy, output logic [15:0] sins);
    int guard;
    logic s;
    nbusy = 0;
    sins = 16'd0;
    if (ld) begin
      bus.i_load = 1'b1;
      bus.i_d = d;
      tick();
      bus.i_load = 1'b0;
      check("load_value", 64'(bus.o_o), 64'(d));
    end
    bus.i_start = 1'b1;
    bus.i_mode = mode;
    bus.i_amt = amt;
    tick();
    bus.i_start = 1'b0;
    guard = 0;
    while (bus.o_busy && guard < 40) begin
      if (bus.o_done) check("done_with_busy", 64'(bus.o_done), 64'd0);
      s = sin_rand ? 1'($urandom_range(1, 0)) : sin_val;
      bus.i_sin = s;
      sins[nbusy] = s;
      bus.i_load = 1'($urandom_range(1, 0));
      bus.i_start = 1'($urandom_range(1, 0));
      bus.i_mode = 3'($urandom_range(7, 0));
      bus.i_amt = 4'($urandom_range(15, 0));
      bus.i_d = 8'($urandom_range(255, 0));
      tick();
      nbusy++;
      guard++;
    end
    bus.i_load = 1'b0;
    bus.i_start = 1'b0;
    if (guard >= 40) check("busy_timeout", 64'(bus.o_busy), 64'd0);
    check("done_pulse", 64'(bus.o_done), 64'd1);
  endtask

  initial begin
    int nb;
    logic [15:0] sins;
    logic [7:0] m_o;
    logic m_sout;
    logic [8:0] exp;
    logic [2:0] md;
    logic [3:0] am;
    bit ld;
    logic [7:0] dd;

    vecs[0] = '{1'b1, 8'hB4, 3'd0, 4'd3,  1'b0, 8'hA0, 1'b1, 3};
    vecs[1] = '{1'b1, 8'h96, 3'd2, 4'd2,  1'b0, 8'hE5, 1'b1, 2};
    vecs[2] = '{1'b1, 8'h81, 3'd4, 4'd9,  1'b0, 8'h81, 1'b1, 8};
    vecs[3] = '{1'b1, 8'h00, 3'd5, 4'd4,  1'b1, 8'h0F, 1'b0, 4};
    vecs[4] = '{1'b1, 8'hA5, 3'd3, 4'd8,  1'b0, 8'hA5, 1'b1, 8};
    vecs[5] = '{1'b1, 8'hFF, 3'd1, 4'd15, 1'b0, 8'h00, 1'b1, 8};
    vecs[6] = '{1'b1, 8'h5A, 3'd7, 4'd5,  1'b0, 8'h5A, 1'b1, 5};
    vecs[7] = '{1'b1, 8'h3C, 3'd6, 4'd3,  1'b0, 8'h07, 1'b1, 3};
    vecs[8] = '{1'b0, 8'h00, 3'd0, 4'd0,  1'b0, 8'h07, 1'b1, 0};

    bus.i_load = 1'b0; bus.i_start = 1'b0; bus.i_mode = 3'd0;
    bus.i_amt = 4'd0; bus.i_sin = 1'b0; bus.i_d = 8'd0;

    #12;
    check("reset_state", 64'({bus.o_o, bus.o_sout, bus.o_busy, bus.o_done}), 64'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].ld, vecs[i].d, vecs[i].mode, vecs[i].amt, 1'b0, vecs[i].sin, nb, sins);
      check($sformatf("vec%0d_o", i), 64'(bus.o_o), 64'(vecs[i].exp_o));
      check($sformatf("vec%0d_sout", i), 64'(bus.o_sout), 64'(vecs[i].exp_sout));
      check($sformatf("vec%0d_busy_cycles", i), 64'(nb), 64'(vecs[i].exp_busy));
    end
    tick();
    check("done_single_pulse", 64'({bus.o_busy, bus.o_done}), 64'd0);

    // Back-to-back: second START issued in the DONE cycle of the first.
    do_op(1'b1, 8'h00, 3'd5, 4'd4, 1'b0, 1'b1, nb, sins);
    check("b2b_first_o", 64'(bus.o_o), 64'h0F);
    do_op(1'b0, 8'h00, 3'd0, 4'd2, 1'b0, 1'b0, nb, sins);
    check("b2b_second_o", 64'(bus.o_o), 64'h3C);
    check("b2b_second_busy", 64'(nb), 64'd2);

    // LOAD and START together: load wins, no operation, no DONE.
    bus.i_load = 1'b1; bus.i_start = 1'b1; bus.i_d = 8'h33;
    bus.i_mode = 3'd0; bus.i_amt = 4'd3;
    tick();
    bus.i_load = 1'b0; bus.i_start = 1'b0;
    check("load_start_o", 64'(bus.o_o), 64'h33);
    check("load_start_busy_done", 64'({bus.o_busy, bus.o_done}), 64'd0);
    tick();
    check("load_start_no_done", 64'({bus.o_busy, bus.o_done, bus.o_o}), 64'h33);

    // Asynchronous reset in the middle of a clock period.
    #2 rst = 1'b1;
    #1 check("async_reset", 64'({bus.o_o, bus.o_sout, bus.o_busy, bus.o_done}), 64'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    // Reset during cycle 2 of a 5-shift operation.
    bus.i_load = 1'b1; bus.i_d = 8'hFF; tick(); bus.i_load = 1'b0;
    bus.i_start = 1'b1; bus.i_mode = 3'd1; bus.i_amt = 4'd5; tick(); bus.i_start = 1'b0;
    check("run_started", 64'(bus.o_busy), 64'd1);
    tick();
    #2 rst = 1'b1;
    #1 check("run_abort", 64'({bus.o_o, bus.o_sout, bus.o_busy, bus.o_done}), 64'd0);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("after_abort_idle", 64'({bus.o_o, bus.o_busy, bus.o_done}), 64'd0);
    end

    // Random operations against the closed-form model (state known zero after the abort).
    m_o = 8'd0;
    m_sout = 1'b0;
    for (int t = 0; t < 40; t++) begin
      ld = (t == 0) ? 1'b1 : 1'($urandom_range(1, 0));
      dd = 8'($urandom_range(255, 0));
      md = 3'($urandom_range(7, 0));
      am = 4'($urandom_range(15, 0));
      do_op(ld, dd, md, am, 1'b1, 1'b0, nb, sins);
      if (ld) m_o = dd;
      exp = ref_op(md, m_o, m_sout, am, sins);
      m_sout = exp[8];
      m_o = exp[7:0];
      check($sformatf("rand%0d_o", t), 64'(bus.o_o), 64'(m_o));
      check($sformatf("rand%0d_sout", t), 64'(bus.o_sout), 64'(m_sout));
      check($sformatf("rand%0d_busy", t), 64'(nb), 64'((am > 4'd8) ? 8 : int'(am)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
